elink_frame_assembler: RTL and testbench
========================================

// Module: elink_frame_assembler
// PURPOSE
//  Parametrised successor to the eLink byte aligner. Assembles byte-masked
//  deserializer beats into fixed-size frames with protocol checking.
//  Buffers completed frames in an output FIFO with valid/ready handshake.
//  Keeps saturating statistics. Sits between the eLink deserializer and the transaction decoder.
// PARAMETERS
//  IN_BYTES     8   bytes per input beat (>=2)
//  FRAME_BYTES  14  bytes per frame (> IN_BYTES)
//  FIFO_DEPTH   4   output frame FIFO entries (power of 2, >=2)
//  CNT_W        16  width of statistics counters
// PORTS
//  clk         in   1               clock
//  rst_n       in   1               asynchronous reset, active low
//  in_valid    in   1               beat present (no backpressure to link)
//  in_data     in   IN_BYTES*8      beat data, lane k = in_data[8k+7:8k]
//  in_mask     in   IN_BYTES        lane-valid mask
//  out_frame   out  FRAME_BYTES*8   frame; byte 0 (first received) at MSB
//  out_valid   out  1               FIFO head valid
//  out_ready   in   1               consumer accepts head
//  busy        out  1               frame assembly in progress
//  cnt_ok      out  CNT_W           frames pushed to FIFO
//  cnt_drop    out  CNT_W           complete frames lost to full FIFO
//  cnt_err     out  CNT_W           frames aborted on protocol error
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, FIFO empty, byte count 0, accumulator 0.
//  Byte order: within a beat, the highest set lane is the earliest byte. Bytes shift in MSB-first.
//  Beat classes (only when in_valid=1; in_valid=0 beats are ignored):
//   HEAD  = mask contiguous from lane 0, non-zero (e.g. 8'b00000111).
//   TAIL  = mask contiguous from lane IN_BYTES-1, not all ones (8'b11100000).
//   FULL  = all ones (classified as FULL, not HEAD).
//   EMPTY = zero: ignored in all states.
//   BAD   = anything else.
//  FSM IDLE: HEAD or FULL -> load bytes, count=popcount, go ASM.
//            TAIL or BAD -> cnt_err++, stay IDLE.
//  FSM ASM:  FULL or TAIL -> append bytes, count += popcount.
//            HEAD -> cnt_err++; restart frame with this beat (stay ASM).
//            BAD -> cnt_err++, go IDLE.
//  Completion: count == FRAME_BYTES after an append -> push frame, go IDLE.
//   If count > FRAME_BYTES -> overrun: cnt_err++, discard, go IDLE.
//   A TAIL leaving count < FRAME_BYTES -> short frame: cnt_err++, go IDLE.
//  Count width: clog2(FRAME_BYTES+IN_BYTES+1); never wraps.
//  busy = (state==ASM).
//  Push: accepted if FIFO not full, or if a pop occurs the same cycle.
//   Otherwise the frame is discarded and cnt_drop++. cnt_ok++ on every accepted push.
//  Latency: completing beat at edge N -> out_valid=1 after edge N+1 (FIFO was empty).
//  Handshake: pop on out_valid&&out_ready. out_frame is stable while out_valid&&!out_ready.
//   out_ready while empty has no effect.
//  Simultaneous push and pop: legal at any fill level; the FIFO level is unchanged.
//  Counters: saturate at all-ones. A single beat increments each counter by at most 1.
//  Reset mid-frame or with a non-empty FIFO: everything is cleared immediately (async).
//   The partial frame and buffered frames are lost and are not counted.
//  No combinational path from in_* to out_*. out_valid is driven only by FIFO state.
// TESTING (IN_BYTES=8, FRAME_BYTES=14, FIFO_DEPTH=4)
//  1. Beats mask 8'h3F data lanes 5..0 = 00..05, then mask 8'hFF bytes 06..0D (lane7 first),
//     out_ready=1 -> one frame 0x000102..0D, out_valid 1 cycle after the 2nd beat, cnt_ok=1.
//  2. HEAD 8'h07 (3 bytes), FULL (8), TAIL 8'hE0 (3) -> frame with bytes 0..13 in
//     order. Then HEAD 8'h07, FULL, TAIL 8'hC0 -> short frame, cnt_err=1, no push.
//  3. Hold out_ready=0 and complete 6 frames -> 4 held, cnt_drop=2, out_frame stable.
//     Then assert out_ready with a 7th frame completing the same cycle -> accepted, cnt_ok=5.
//  4. In IDLE, mask 8'h5A -> cnt_err=1, busy stays 0.
//     In ASM, a HEAD beat -> cnt_err++, frame restarts and later completes correctly.
//  5. Idle/EMPTY beats interleaved between HEAD/FULL/TAIL -> same frame as without the gaps.
//  6. Assert rst_n=0 asynchronously mid-frame with 2 frames buffered -> out_valid=0 and
//     counters 0 before the next edge. A new frame after release is assembled cleanly.

Source files
------------

// File: rtl/elink_frame_assembler.sv
// Assembles byte-masked eLink beats into fixed-size frames and buffers them in an output FIFO.
// Frame protocol errors, frames lost to a full FIFO and accepted frames each have a saturating counter.
module elink_frame_assembler #(
  parameter int unsigned IN_BYTES    = 8,
  parameter int unsigned FRAME_BYTES = 14,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [IN_BYTES*8-1:0]    in_data,
  input  logic [IN_BYTES-1:0]      in_mask,
  output logic [FRAME_BYTES*8-1:0] out_frame,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic [CNT_W-1:0]         cnt_ok,
  output logic [CNT_W-1:0]         cnt_drop,
  output logic [CNT_W-1:0]         cnt_err
);

  localparam int unsigned IW  = IN_BYTES * 8;
  localparam int unsigned FW  = FRAME_BYTES * 8;
  localparam int unsigned CW  = $clog2(FRAME_BYTES + IN_BYTES + 1);
  localparam int unsigned PCW = $clog2(IN_BYTES + 1);
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LW  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {IDLE, ASM} state_t;

  state_t          state;
  logic [FW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic            push_q;
  logic [FW-1:0]   push_frame;

  logic [IN_BYTES-1:0] inv_mask;
  logic                is_empty, is_full, is_head, is_tail, is_bad;
  logic [PCW-1:0]      pop_cnt;
  logic [IW-1:0]       masked;
  logic [FW-1:0]       beat_bytes, load_acc, app_acc;
  logic [CW-1:0]       load_cnt, app_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Beat classification from the lane mask.
  always_comb begin
    inv_mask = ~in_mask;
    is_empty = (in_mask == '0);
    is_full  = (&in_mask);
    is_head  = !is_empty && !is_full && ((in_mask & (in_mask + IN_BYTES'(1))) == '0);
    is_tail  = !is_empty && !is_full && ((inv_mask & (inv_mask + IN_BYTES'(1))) == '0);
    is_bad   = !is_empty && !is_full && !is_head && !is_tail;
  end

  // Valid byte count and valid bytes right-aligned, earliest byte most significant.
  always_comb begin
    pop_cnt = '0;
    masked  = '0;
    for (int i = 0; i < IN_BYTES; i++) begin
      pop_cnt = pop_cnt + PCW'(in_mask[i]);
      if (in_mask[i]) masked[8*i +: 8] = in_data[8*i +: 8];
    end
    if (is_tail) masked = masked >> ((IN_BYTES - 32'(pop_cnt)) * 8);
    beat_bytes = FW'(masked);
    load_acc   = beat_bytes;
    load_cnt   = CW'(pop_cnt);
    app_acc    = (acc << (32'(pop_cnt) * 8)) | beat_bytes;
    app_cnt    = cnt + CW'(pop_cnt);
  end

  // Frame assembly FSM; a completed frame is handed to the FIFO one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      push_q     <= 1'b0;
      push_frame <= '0;
      cnt_err    <= '0;
    end else begin
      push_q <= 1'b0;
      if (in_valid && !is_empty) begin
        case (state)
          IDLE: begin
            if (is_head || is_full) begin
              acc   <= load_acc;
              cnt   <= load_cnt;
              state <= ASM;
            end else begin
              cnt_err <= sat_inc(cnt_err);
            end
          end
          ASM: begin
            if (is_head) begin
              cnt_err <= sat_inc(cnt_err);
              acc     <= load_acc;
              cnt     <= load_cnt;
            end else if (is_bad) begin
              cnt_err <= sat_inc(cnt_err);
              acc     <= '0;
              cnt     <= '0;
              state   <= IDLE;
            end else if (app_cnt == CW'(FRAME_BYTES)) begin
              push_q     <= 1'b1;
              push_frame <= app_acc;
              acc        <= '0;
              cnt        <= '0;
              state      <= IDLE;
            end else if (app_cnt > CW'(FRAME_BYTES) || is_tail) begin
              cnt_err <= sat_inc(cnt_err);
              acc     <= '0;
              cnt     <= '0;
              state   <= IDLE;
            end else begin
              acc <= app_acc;
              cnt <= app_cnt;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy = (state == ASM);

  logic [FW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_next;
  logic [LW-1:0] level, level_next;
  logic          pop, fifo_full, wr_en, drop;
  logic [FW-1:0] head_next;

  // FIFO control; the head entry is registered so out_frame comes straight from a flop.
  always_comb begin
    pop        = out_valid && out_ready;
    fifo_full  = (level == LW'(FIFO_DEPTH));
    wr_en      = push_q && (!fifo_full || pop);
    drop       = push_q && !wr_en;
    rd_next    = pop ? rd_ptr + PW'(1) : rd_ptr;
    level_next = level + LW'(wr_en) - LW'(pop);
    head_next  = (wr_en && (wr_ptr == rd_next)) ? push_frame : mem[rd_next];
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_frame;
  end

  // FIFO pointers, registered head/valid and push statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_frame <= '0;
      cnt_ok    <= '0;
      cnt_drop  <= '0;
    end else begin
      rd_ptr    <= rd_next;
      level     <= level_next;
      out_valid <= (level_next != '0);
      out_frame <= (level_next != '0) ? head_next : '0;
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
        cnt_ok <= sat_inc(cnt_ok);
      end
      if (drop) cnt_drop <= sat_inc(cnt_drop);
    end
  end

endmodule

// File: tb/tb_elink_frame_assembler.sv
// Directed and randomized bench for elink_frame_assembler against a byte-queue reference model.
module tb_elink_frame_assembler;

  localparam int unsigned IN_BYTES    = 8;
  localparam int unsigned FRAME_BYTES = 14;
  localparam int unsigned FIFO_DEPTH  = 4;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned FW          = FRAME_BYTES * 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  in_valid = 1'b0;
  logic [IN_BYTES*8-1:0] in_data = '0;
  logic [IN_BYTES-1:0]   in_mask = '0;
  logic [FW-1:0]         out_frame;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic                  busy;
  logic [CNT_W-1:0]      cnt_ok, cnt_drop, cnt_err;

  elink_frame_assembler #(
    .IN_BYTES(IN_BYTES), .FRAME_BYTES(FRAME_BYTES), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_mask(in_mask),
    .out_frame(out_frame), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .cnt_ok(cnt_ok), .cnt_drop(cnt_drop), .cnt_err(cnt_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0]    bytes_q[$];
  bit            in_frame;
  logic [FW-1:0] fq[$];
  bit            pend;
  logic [FW-1:0] pend_frame;
  int unsigned   m_ok, m_drop, m_err;
  logic [7:0]    nb;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned sat(input int unsigned v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  task automatic model_clear();
    bytes_q.delete();
    fq.delete();
    in_frame = 0;
    pend = 0;
    pend_frame = '0;
    m_ok = 0; m_drop = 0; m_err = 0;
  endtask

  // One clock edge of the reference: deferred push against FIFO, then the sampled beat.
  task automatic model_edge(input logic v, input logic [7:0] m, input logic [63:0] d, input logic rdy);
    bit pop, accept, head, tail, full;
    int p;
    logic [7:0] nbytes[$];
    logic [FW-1:0] f;
    pop = (fq.size() != 0) && rdy;
    accept = pend && ((fq.size() < FIFO_DEPTH) || pop);
    if (pend && !accept) m_drop = sat(m_drop);
    if (pop) void'(fq.pop_front());
    if (accept) begin
      fq.push_back(pend_frame);
      m_ok = sat(m_ok);
    end
    pend = 0;
    if (v && m != 8'h00) begin
      p = 0;
      for (int l = 7; l >= 0; l--) if (m[l]) begin p++; nbytes.push_back(d[8*l +: 8]); end
      full = (m == 8'hFF);
      head = !full && (m == 8'((1 << p) - 1));
      tail = !full && (m == 8'(((1 << p) - 1) << (8 - p)));
      if (!in_frame) begin
        if (head || full) begin bytes_q = nbytes; in_frame = 1; end
        else m_err = sat(m_err);
      end else if (head) begin
        m_err = sat(m_err);
        bytes_q = nbytes;
      end else if (!(full || tail)) begin
        m_err = sat(m_err);
        in_frame = 0;
        bytes_q.delete();
      end else begin
        foreach (nbytes[i]) bytes_q.push_back(nbytes[i]);
        if (bytes_q.size() == FRAME_BYTES) begin
          f = '0;
          foreach (bytes_q[i]) f = (f << 8) | FW'(bytes_q[i]);
          pend = 1;
          pend_frame = f;
          in_frame = 0;
          bytes_q.delete();
        end else if (bytes_q.size() > FRAME_BYTES || tail) begin
          m_err = sat(m_err);
          in_frame = 0;
          bytes_q.delete();
        end
      end
    end
  endtask

  task automatic check_all();
    chk("out_valid", out_valid, fq.size() != 0);
    if (fq.size() != 0) chk("out_frame", out_frame, fq[0]);
    chk("busy", busy, in_frame);
    chk("cnt_ok", cnt_ok, m_ok);
    chk("cnt_drop", cnt_drop, m_drop);
    chk("cnt_err", cnt_err, m_err);
  endtask

  task automatic step(input logic v, input logic [7:0] m, input logic [63:0] d, input logic rdy);
    in_valid = v; in_mask = m; in_data = d; out_ready = rdy;
    @(posedge clk);
    model_edge(v, m, d, rdy);
    #1;
    check_all();
  endtask

  // Beat whose set lanes carry consecutive bytes from nb, highest lane first; other lanes random.
  task automatic send(input logic [7:0] m, input logic rdy);
    logic [63:0] d;
    d = {$urandom, $urandom};
    for (int l = 7; l >= 0; l--) if (m[l]) begin d[8*l +: 8] = nb; nb = nb + 8'd1; end
    step(1'b1, m, d, rdy);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 8'(($urandom)), {$urandom, $urandom}, rdy);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    model_clear();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ok", cnt_ok, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] mk;
    int p, r;
    model_clear();
    #12;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_frame", out_frame, 0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_cnt_ok", cnt_ok, 0);
    chk("reset_cnt_drop", cnt_drop, 0);
    chk("reset_cnt_err", cnt_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: 6-byte head then full beat
    nb = 8'h00;
    send(8'h3F, 1'b1);
    send(8'hFF, 1'b1);
    chk("t1_latency", out_valid, 1'b0);
    idle(1'b1);
    chk("t1_frame", out_frame, 112'h000102030405060708090A0B0C0D);
    chk("t1_cnt_ok", cnt_ok, 1);
    idle(1'b1);

    // 2: head/full/tail frame, then a short frame
    do_reset();
    nb = 8'h00;
    send(8'h07, 1'b0); send(8'hFF, 1'b0); send(8'hE0, 1'b0);
    idle(1'b0);
    chk("t2_frame", out_frame, 112'h000102030405060708090A0B0C0D);
    send(8'h07, 1'b1); send(8'hFF, 1'b1); send(8'hC0, 1'b1);
    chk("t2_short_err", cnt_err, 1);
    idle(1'b1);
    chk("t2_no_push", cnt_ok, 1);

    // 3: overflow with consumer stalled, then push and pop on the same edge
    do_reset();
    nb = 8'h40;
    for (int k = 0; k < 6; k++) begin send(8'h3F, 1'b0); send(8'hFF, 1'b0); end
    idle(1'b0); idle(1'b0);
    chk("t3_drop", cnt_drop, 2);
    chk("t3_held", cnt_ok, 4);
    send(8'h3F, 1'b0); send(8'hFF, 1'b0);
    idle(1'b1);
    chk("t3_same_cycle_ok", cnt_ok, 5);
    chk("t3_drop_kept", cnt_drop, 2);
    for (int k = 0; k < 6; k++) idle(1'b1);

    // 4: bad mask in IDLE, head restart in ASM
    do_reset();
    send(8'h5A, 1'b1);
    chk("t4_bad_err", cnt_err, 1);
    chk("t4_bad_busy", busy, 1'b0);
    send(8'h07, 1'b1); send(8'h3F, 1'b1); send(8'hFF, 1'b1);
    idle(1'b1);
    chk("t4_restart_ok", cnt_ok, 1);
    chk("t4_restart_err", cnt_err, 2);
    idle(1'b1);

    // 5: gaps between beats do not change the frame
    do_reset();
    nb = 8'h20;
    send(8'h07, 1'b0); idle(1'b0); send(8'h00, 1'b0);
    send(8'hFF, 1'b0); idle(1'b0); idle(1'b0); send(8'h00, 1'b0);
    send(8'hE0, 1'b0);
    idle(1'b0);
    chk("t5_frame", out_frame, 112'h202122232425262728292A2B2C2D);
    idle(1'b1); idle(1'b1);

    // 6: async reset mid-frame with two frames buffered
    do_reset();
    for (int k = 0; k < 2; k++) begin send(8'h3F, 1'b0); send(8'hFF, 1'b0); end
    send(8'h07, 1'b0);
    chk("t6_buffered", cnt_ok, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", out_valid, 1'b0);
    chk("t6_async_ok", cnt_ok, 0);
    chk("t6_async_busy", busy, 1'b0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    nb = 8'h00;
    send(8'h3F, 1'b1); send(8'hFF, 1'b1);
    idle(1'b1);
    chk("t6_after_frame", out_frame, 112'h000102030405060708090A0B0C0D);
    idle(1'b1);

    // Randomized beats and consumer stalls
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 9);
      p = $urandom_range(1, 7);
      case (r)
        0:       mk = 8'($urandom);
        1:       mk = 8'h00;
        2, 3:    mk = 8'((1 << p) - 1);
        4, 5:    mk = 8'hFF;
        6, 7:    mk = 8'(((1 << p) - 1) << (8 - p));
        default: mk = 8'($urandom);
      endcase
      step(r != 0, mk, {$urandom, $urandom}, $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
